// File: rtl/parking_gate_controller_if.sv
// parking_gate_controller_if: raw lane sensors, occupancy count and the controller's pulse/gate outputs.
interface parking_gate_controller_if;
    logic       entry_a;
    logic       entry_b;
    logic       exit_a;
    logic       exit_b;
    logic [6:0] count;
    logic       inc;
    logic       dec;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic       full;
    logic       seq_error;
    modport master (
        output entry_a, entry_b, exit_a, exit_b, count,
        input  inc, dec, entry_gate_open, exit_gate_open, full, seq_error
    );
    modport slave (
        input  entry_a, entry_b, exit_a, exit_b, count,
        output inc, dec, entry_gate_open, exit_gate_open, full, seq_error
    );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: debounces two gate lanes, tracks vehicles per lane and drives
// occupancy inc/dec pulses, barrier commands and the lot-full flag.
module parking_gate_controller #(
    parameter int CAPACITY        = 99,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                     clk,
    input logic                     reset,
    parking_gate_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, S_A, S_AB, S_B} state_t;
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] CAP     = 7'(CAPACITY);
    // sensor bits: 0 entry_a, 1 entry_b, 2 exit_a, 3 exit_b
    logic [3:0] raw, s1, s2, db, db_prev;
    logic [3:0] cnt [4];
    logic [1:0] ab [2];
    logic [1:0] ab_prev [2];
    state_t     state [2];
    state_t     state_next [2];
    logic [1:0] pass, err, pass_q, err_q;
    logic       full_q, entry_gate_q, exit_gate_q, inc_q, dec_q, seq_error_q;
    assign raw        = {bus.exit_b, bus.exit_a, bus.entry_b, bus.entry_a};
    assign ab[0]      = {db[0], db[1]};
    assign ab[1]      = {db[2], db[3]};
    assign ab_prev[0] = {db_prev[0], db_prev[1]};
    assign ab_prev[1] = {db_prev[2], db_prev[3]};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            db_prev <= db;
            for (int i = 0; i < 4; i++)
                if (s2[i] == db[i]) cnt[i] <= '0;
                else if (cnt[i] == DB_LAST) begin
                    cnt[i] <= '0;
                    db[i]  <= s2[i];
                end else cnt[i] <= cnt[i] + 4'd1;
        end
    end
    // IDLE errors fire only on the change into (0,1) so a held bad pattern gives one pulse
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            state_next[l] = state[l];
            pass[l]       = 1'b0;
            err[l]        = 1'b0;
            case (state[l])
                IDLE: begin
                    state_next[l] = ab[l] == 2'b10 ? S_A : IDLE;
                    err[l]        = ab[l] == 2'b01 && ab_prev[l] != 2'b01;
                end
                S_A: begin
                    state_next[l] = ab[l] == 2'b11 ? S_AB : ab[l] == 2'b10 ? S_A : IDLE;
                    err[l]        = ab[l] == 2'b01;
                end
                S_AB: begin
                    state_next[l] = ab[l] == 2'b01 ? S_B : ab[l] == 2'b10 ? S_A :
                                    ab[l] == 2'b00 ? IDLE : S_AB;
                    err[l]        = ab[l] == 2'b00;
                end
                default: begin
                    state_next[l] = ab[l] == 2'b11 ? S_AB : ab[l] == 2'b01 ? S_B : IDLE;
                    pass[l]       = ab[l] == 2'b00;
                    err[l]        = ab[l] == 2'b10;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= '{IDLE, IDLE};
            pass_q       <= '0;
            err_q        <= '0;
            full_q       <= 1'b0;
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            inc_q        <= 1'b0;
            dec_q        <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state        <= state_next;
            pass_q       <= pass;
            err_q        <= err;
            full_q       <= bus.count >= CAP;
            inc_q        <= pass_q[0] & ~pass_q[1];
            dec_q        <= pass_q[1] & ~pass_q[0];
            seq_error_q  <= |err_q;
            // an open entry gate stays open in S_A even if full rises
            entry_gate_q <= state[0] == S_A ? (entry_gate_q | ~full_q) :
                            (state[0] == S_AB || state[0] == S_B);
            exit_gate_q  <= state[1] != IDLE;
        end
    end
    assign bus.inc             = inc_q;
    assign bus.dec             = dec_q;
    assign bus.entry_gate_open = entry_gate_q;
    assign bus.exit_gate_open  = exit_gate_q;
    assign bus.full            = full_q;
    assign bus.seq_error       = seq_error_q;
endmodule
